// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: GUARD blanking then DRIVE per slot, one digit per slot.
// Optional PWM dimming of the anode within DRIVE when SEG_SCAN_DIMMING_EN is defined.
module seg_scan_mux #(
  parameter int DIGITS    = 8,
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int GUARD_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int DWELL     = CLK_HZ / SCAN_HZ;
  localparam int DRIVE_CYC = DWELL - GUARD_CYC;
  localparam int CW        = $clog2(DWELL + 1);
  localparam int SW        = $clog2(DIGITS);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [SW-1:0]     slot, slot_d;
  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [3:0]        cur_val;
  logic              upper_zero;
  logic              dark;

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'h0: seg_enc = 7'h40;
      4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;
      4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;
      4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;
      4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;
      4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;
      4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;
      4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;
      default: seg_enc = 7'h0E;
    endcase
  endfunction

  // Leading-zero test looks at the current digit and every digit above it.
  always_comb begin
    cur_val    = bcd[int'(slot)*4 +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(slot) && bcd[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    dark = !digit_en[slot] || (lz_blank && (slot != '0) && upper_zero);
  end

`ifdef SEG_SCAN_DIMMING_EN
  logic [CW-1:0] on_q, on_d, on_calc;
  always_comb on_calc = CW'(((int'(bright) + 1) * DRIVE_CYC) >> 4);
`else
  logic unused_bright;
  assign unused_bright = ^bright;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    slot_d  = slot;
    an_d    = an;
    seg_d   = seg;
    dp_d    = dp;
`ifdef SEG_SCAN_DIMMING_EN
    on_d    = on_q;
`endif
    case (state)
      GUARD: begin
        if (cnt == CW'(GUARD_CYC - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
`ifdef SEG_SCAN_DIMMING_EN
          on_d    = on_calc;
`endif
          if (!dark) begin
`ifdef SEG_SCAN_DIMMING_EN
            an_d  = (on_calc != '0) ? ~(DIGITS'(1) << slot) : '1;
`else
            an_d  = ~(DIGITS'(1) << slot);
`endif
            seg_d = seg_enc(cur_val);
            dp_d  = ~dp_in[slot];
          end else begin
            an_d  = '1;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        if (cnt == CW'(DRIVE_CYC - 1)) begin
          state_d = GUARD;
          cnt_d   = '0;
          slot_d  = (slot == SW'(DIGITS - 1)) ? '0 : slot + SW'(1);
          an_d    = '1;
          seg_d   = 7'h7F;
          dp_d    = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
`ifdef SEG_SCAN_DIMMING_EN
          if (cnt + CW'(1) == on_q) an_d = '1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= GUARD;
      cnt   <= '0;
      slot  <= '0;
      an    <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
`ifdef SEG_SCAN_DIMMING_EN
      on_q  <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      slot  <= slot_d;
      an    <= an_d;
      seg   <= seg_d;
      dp    <= dp_d;
`ifdef SEG_SCAN_DIMMING_EN
      on_q  <= on_d;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=4, DWELL=10, GUARD_CYC=2.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

`ifdef SEG_SCAN_DIMMING_EN
  localparam int ON7 = 4;
  localparam int ON3 = 2;
`else
  localparam int ON7 = 8;
  localparam int ON3 = 8;
`endif

  seg_scan_mux #(.DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .GUARD_CYC(2)) dut (
    .clk(clk), .rst(rst), .bcd(bcd), .dp_in(dp_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .bright(bright), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One full 10-cycle slot: 2 guard samples, then 8 drive samples.
  task automatic run_slot(input string name, input logic [3:0] lit_an,
                          input logic [6:0] lit_seg, input logic lit_dp, input int on_cyc);
    logic [11:0] exp;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) exp = {4'hF, 7'h7F, 1'b1};
      else exp = {((i - 2) < on_cyc) ? lit_an : 4'hF, lit_seg, lit_dp};
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL %s cyc %0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 name, i, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: got an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
    end
    @(posedge clk); #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: got an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    bcd = 16'h4321; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0; bright = 4'hF;
    do_reset();
    run_slot("scan_d0", 4'hE, 7'h79, 1'b1, 8);
    run_slot("scan_d1", 4'hD, 7'h24, 1'b1, 8);
    run_slot("scan_d2", 4'hB, 7'h30, 1'b1, 8);
    run_slot("scan_d3", 4'h7, 7'h19, 1'b1, 8);
    run_slot("scan_wrap", 4'hE, 7'h79, 1'b1, 8);
  endtask

  task automatic test_lz();
    bcd = 16'h0050; lz_blank = 1'b1;
    do_reset();
    run_slot("lz_d0", 4'hE, 7'h40, 1'b1, 8);
    run_slot("lz_d1", 4'hD, 7'h12, 1'b1, 8);
    run_slot("lz_d2", 4'hF, 7'h7F, 1'b1, 8);
    run_slot("lz_d3", 4'hF, 7'h7F, 1'b1, 8);
    lz_blank = 1'b0;
    do_reset();
    run_slot("nolz_d0", 4'hE, 7'h40, 1'b1, 8);
    run_slot("nolz_d1", 4'hD, 7'h12, 1'b1, 8);
    run_slot("nolz_d2", 4'hB, 7'h40, 1'b1, 8);
    run_slot("nolz_d3", 4'h7, 7'h40, 1'b1, 8);
  endtask

  task automatic test_dark_dp();
    bcd = 16'h4321; digit_en = 4'b1011; dp_in = 4'b0001;
    do_reset();
    run_slot("dk_d0", 4'hE, 7'h79, 1'b0, 8);
    run_slot("dk_d1", 4'hD, 7'h24, 1'b1, 8);
    run_slot("dk_d2", 4'hF, 7'h7F, 1'b1, 8);
    run_slot("dk_d3", 4'h7, 7'h19, 1'b1, 8);
    run_slot("dk_wrap", 4'hE, 7'h79, 1'b0, 8);
    digit_en = 4'hF; dp_in = 4'h0;
  endtask

  task automatic test_mid_change();
    logic [11:0] exp;
    bcd = 16'h1111;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp = (i < 2) ? {4'hF, 7'h7F, 1'b1} : {4'hE, 7'h79, 1'b1};
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL mid_hold cyc %0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 i, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
      end
      if (i == 5) bcd = 16'h2222;
      @(posedge clk); #1;
    end
    run_slot("mid_next", 4'hD, 7'h24, 1'b1, 8);
  endtask

  task automatic test_reset_mid();
    bcd = 16'h4321;
    do_reset();
    run_slot("rm_d0", 4'hE, 7'h79, 1'b1, 8);
    run_slot("rm_d1", 4'hD, 7'h24, 1'b1, 8);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({an, seg} !== {4'hB, 7'h30}) begin
      errors++;
      $display("FAIL rm_pre: got an=%h seg=%h want an=b seg=30", an, seg);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL rm_async: got an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    run_slot("rm_after", 4'hE, 7'h79, 1'b1, 8);
    run_slot("rm_after_d1", 4'hD, 7'h24, 1'b1, 8);
  endtask

  task automatic test_dimming();
    bcd = 16'h4321;
    bright = 4'd7;
    do_reset();
    run_slot("dim_b7", 4'hE, 7'h79, 1'b1, ON7);
    bright = 4'd15;
    do_reset();
    run_slot("dim_b15", 4'hE, 7'h79, 1'b1, 8);
    bright = 4'd3;
    do_reset();
    run_slot("dim_b3", 4'hE, 7'h79, 1'b1, ON3);
    bright = 4'hF;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_dark_dp();
    test_mid_change();
    test_reset_mid();
    test_dimming();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
